// File: rtl/frame_window_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frame_window_pkg
// Brief   : Shared state encoding, default pixel width and window clamp helper
// Revision: 1.0 - initial release
// ============================================================================
package frame_window_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } fw_state_t;

    // Pixel width for the default 8-bit x 3-channel configuration
    localparam int PW = 24;

    // Visible extent of a window starting at pos inside a display of size disp
    function automatic int unsigned clamp_extent(input int unsigned pos,
                                                 input int unsigned size,
                                                 input int unsigned disp);
        if (pos >= disp) begin
            return 0;
        end else if (size < disp - pos) begin
            return size;
        end else begin
            return disp - pos;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo_fwft
// Brief   : Single-clock first-word-fall-through FIFO with synchronous flush
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A write into a full FIFO is only legal when the same-cycle read frees a slot
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(wr_ok);
            rptr  <= rptr + AW'(rd_ok);
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_window_fill.sv
`default_nettype none
// ============================================================================
// Module  : frame_window_fill
// Brief   : Rasterises a windowed pixel stream into a full frame with border fill
// Revision: 1.0 - initial release
// ============================================================================
module frame_window_fill
    import frame_window_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int H_DISP     = 1920,
    parameter int V_DISP     = 1080,
    parameter int X_WIDTH    = 12,
    parameter int Y_WIDTH    = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [X_WIDTH-1:0]             win_x,
    input  logic [Y_WIDTH-1:0]             win_y,
    input  logic [X_WIDTH-1:0]             win_w,
    input  logic [Y_WIDTH-1:0]             win_h,
    input  logic                           fill_en,
    input  logic [DATA_WIDTH*CHANNELS-1:0] fill_color,
    input  logic [DATA_WIDTH*CHANNELS-1:0] s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [DATA_WIDTH*CHANNELS-1:0] m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           m_sof,
    output logic                           m_eol,
    output logic                           m_inwin,
    output logic [15:0]                    excess_cnt,
    output logic                           abort_flag
);

    localparam int                 PIX_W    = DATA_WIDTH * CHANNELS;
    localparam logic [X_WIDTH-1:0] X_LAST   = X_WIDTH'(H_DISP - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST   = Y_WIDTH'(V_DISP - 1);
    localparam logic [FIFO_AW:0]   FIFO_TOP = (FIFO_AW+1)'(FIFO_DEPTH);

    fw_state_t          state;
    logic [X_WIDTH-1:0] x_pos;
    logic [Y_WIDTH-1:0] y_pos;
    logic [X_WIDTH-1:0] win_x_q;
    logic [Y_WIDTH-1:0] win_y_q;
    logic [X_WIDTH:0]   ext_w;
    logic [Y_WIDTH:0]   ext_h;
    logic               fill_en_q;
    logic [PIX_W-1:0]   fill_color_q;

    logic [X_WIDTH:0]   ew_next;
    logic [Y_WIDTH:0]   eh_next;
    logic [X_WIDTH:0]   dx;
    logic [Y_WIDTH:0]   dy;
    logic               in_win;
    logic               out_free;
    logic               line_end;
    logic               at_last;
    logic               load_win;
    logic               load_fill;
    logic               step;
    logic               draining;
    logic [1:0]         drop_inc;
    logic [16:0]        excess_sum;

    logic [PIX_W-1:0]   fifo_dout;
    logic               fifo_empty;
    logic               fifo_wr;
    logic               fifo_rd;
    logic [FIFO_AW:0]   fifo_count;

    assign ew_next = (X_WIDTH+1)'(clamp_extent(32'(win_x), 32'(win_w), 32'(H_DISP)));
    assign eh_next = (Y_WIDTH+1)'(clamp_extent(32'(win_y), 32'(win_h), 32'(V_DISP)));

    // Unsigned wrap of the offset makes positions left/above the window compare large
    assign dx       = {1'b0, x_pos} - {1'b0, win_x_q};
    assign dy       = {1'b0, y_pos} - {1'b0, win_y_q};
    assign in_win   = (dx < ext_w) && (dy < ext_h);
    assign out_free = !m_valid || m_ready;
    assign line_end = (x_pos == X_LAST);
    assign at_last  = line_end && (y_pos == Y_LAST);
    assign draining = (state == ST_DRAIN) && !frame_start;

    always_comb begin
        load_win  = 1'b0;
        load_fill = 1'b0;
        step      = 1'b0;
        if (state == ST_ACTIVE && !frame_start) begin
            if (in_win) begin
                load_win = out_free && !fifo_empty;
                step     = load_win;
            end else if (fill_en_q) begin
                load_fill = out_free;
                step      = out_free;
            end else begin
                step = 1'b1;
            end
        end
    end

    always_comb begin
        case (state)
            ST_ACTIVE: s_ready = (fifo_count != FIFO_TOP);
            ST_DRAIN:  s_ready = 1'b1;
            default:   s_ready = 1'b0;
        endcase
    end

    assign fifo_wr    = s_valid && s_ready && (state == ST_ACTIVE);
    assign fifo_rd    = load_win || (draining && !fifo_empty);
    assign drop_inc   = 2'(draining && s_valid) + 2'(draining && !fifo_empty);
    assign excess_sum = {1'b0, excess_cnt} + 17'(drop_inc);

    sync_fifo_fwft #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (frame_start),
        .wr_en   (fifo_wr),
        .wr_data (s_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_dout),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            x_pos        <= '0;
            y_pos        <= '0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            ext_w        <= '0;
            ext_h        <= '0;
            fill_en_q    <= 1'b0;
            fill_color_q <= '0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_sof        <= 1'b0;
            m_eol        <= 1'b0;
            m_inwin      <= 1'b0;
            excess_cnt   <= '0;
            abort_flag   <= 1'b0;
        end else if (frame_start) begin
            win_x_q      <= win_x;
            win_y_q      <= win_y;
            ext_w        <= ew_next;
            ext_h        <= eh_next;
            fill_en_q    <= fill_en;
            fill_color_q <= fill_color;
            x_pos        <= '0;
            y_pos        <= '0;
            state        <= ST_ACTIVE;
            if (state == ST_ACTIVE) begin
                abort_flag <= 1'b1;
                m_valid    <= 1'b0;
            end else begin
                // A finished frame keeps its last beat until the sink takes it
                if (state == ST_DRAIN) begin
                    abort_flag <= 1'b0;
                end
                if (m_ready) begin
                    m_valid <= 1'b0;
                end
            end
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (load_win || load_fill) begin
                        m_valid <= 1'b1;
                        m_data  <= load_win ? fifo_dout : fill_color_q;
                        m_sof   <= (x_pos == '0) && (y_pos == '0);
                        m_eol   <= line_end;
                        m_inwin <= load_win;
                    end else if (out_free) begin
                        m_valid <= 1'b0;
                    end
                    if (step) begin
                        if (at_last) begin
                            state      <= ST_DRAIN;
                            excess_cnt <= '0;
                        end else if (line_end) begin
                            x_pos <= '0;
                            y_pos <= y_pos + Y_WIDTH'(1);
                        end else begin
                            x_pos <= x_pos + X_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                    excess_cnt <= excess_sum[16] ? 16'hFFFF : excess_sum[15:0];
                    if (fifo_empty && !s_valid) begin
                        state      <= ST_IDLE;
                        abort_flag <= 1'b0;
                    end
                end
                default: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
